dual_lane_feeder: RTL and testbench
===================================

Name: dual_lane_feeder

Overview:
- Upstream stage of the dual-pipeline consumer FSM; produces its pipeline1_outputs, pipeline2_outputs and valid[1:0].
- Each of two producer lanes feeds a DEPTH-entry FIFO through a valid/ready handshake.
- Pops at most one word per lane per cycle into registered outputs; consumer has no backpressure.
- Drives the idle code (low 5 bits = 5'h1f) when a lane has nothing to present, and counts producer words that collide with that code.

Parameters:
- DEPTH, 4, entries per lane FIFO; power of 2, >= 2
- SYNC_LANES, 0, 1 = pop both lanes only when both FIFOs non-empty (lockstep); 0 = lanes independent

Ports:
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- lane0_data  in  32  lane 0 producer word
- lane0_valid  in  1  lane 0 word offered
- lane0_ready  out  1  lane 0 FIFO can accept
- lane1_data  in  32  lane 1 producer word
- lane1_valid  in  1  lane 1 word offered
- lane1_ready  out  1  lane 1 FIFO can accept
- flush  in  1  synchronous clear of FIFOs and outputs
- pipeline1_outputs  out  32  registered lane 0 output word
- pipeline2_outputs  out  32  registered lane 1 output word
- valid  out  2  bit0 = pipeline1_outputs valid, bit1 = pipeline2_outputs valid
- fill0  out  $clog2(DEPTH)+1  lane 0 FIFO occupancy
- fill1  out  $clog2(DEPTH)+1  lane 1 FIFO occupancy
- reserved_cnt  out  16  saturating count of accepted reserved-code words

Behaviour:
- Reset (reset_n low, async): FIFOs empty, fill0 = fill1 = 0, valid = 2'b00, pipeline1/2_outputs = 32'h0000_001F, reserved_cnt = 0. Reset mid-transfer discards all buffered data; no partial state survives.
- laneN_ready = !full && !flush, decoded from registered occupancy only. No combinational path from laneN_valid.
- Push: laneN_valid && laneN_ready at the rising edge writes laneN_data at the tail.
- Pop, per cycle:
  - SYNC_LANES = 0: each non-empty lane pops its head into its output register and sets its valid bit for the next cycle; an empty lane clears its valid bit.
  - SYNC_LANES = 1: both lanes pop only when both FIFOs are non-empty; otherwise valid = 2'b00 and neither lane pops.
- Invalid outputs: whenever a valid bit is 0, the matching output is 32'h0000_001F (idle code).
- Latency: word pushed at edge N into an empty FIFO appears on the output, valid high, after edge N+1. Steady throughput is 1 word/cycle/lane.
- Occupancy:
  - Push and pop in the same cycle: fill unchanged.
  - Full: ready = 0, so no push.
  - Empty: no pop.
  - Pointers wrap modulo DEPTH. fill ranges 0..DEPTH.
- flush, sync: at the edge where flush = 1, FIFOs empty, valid = 2'b00, outputs = idle code. Any push offered that cycle is not accepted (ready = 0). reserved_cnt is not cleared.
- reserved_cnt:
  - Increments for each accepted word (handshake completed) whose bits [4:0] == 5'h1f.
  - Both lanes in the same cycle give +2.
  - Saturates at 16'hFFFF, including 16'hFFFE + 2 -> 16'hFFFF.

Optional Feature:
- Macro RESERVED_DROP_EN.
- Defined: an accepted word with [4:0] == 5'h1f is consumed (ready handshake completes) but not written to the FIFO. fill is unchanged for that push, and reserved_cnt still increments.
- Undefined: such words are buffered and forwarded unchanged with valid = 1. The consumer then sees the idle code; reserved_cnt still counts them.

Test Plan:
- Reset then idle: reset_n low mid-cycle, release, no valid inputs -> valid = 00, both outputs 32'h0000_001F, lane0/1_ready = 1, fill = 0.
- Single word, SYNC_LANES = 0: lane0 pushes 32'hDEAD_BEE0 at edge N -> after edge N+1 pipeline1_outputs = 32'hDEAD_BEE0, valid = 01. After edge N+2, valid = 00 and output = idle code.
- Fill to full: hold lane1 valid while lane0/1 are pushed 32'h100, 32'h200, ... with pops blocked via SYNC_LANES = 1 and lane0 idle -> fill1 reaches 4, lane1_ready = 0. Then one lane0 push -> lanes pop in lockstep, words emerge in order, fill1 decrements.
- Flush during streaming: fill0 = 3, flush pulsed one cycle with lane0_valid = 1 -> lane0_ready = 0 that cycle, next cycle fill0 = 0, valid = 00, reserved_cnt unchanged.
- Reserved code: both lanes push 32'h0000_00FF in the same cycle -> reserved_cnt += 2. Forwarded with valid = 11 when RESERVED_DROP_EN is undefined; dropped with fill unchanged when it is defined.
- Async reset mid-operation: fill0 = 2, fill1 = 1, valid = 11, reset_n asserted between edges -> outputs immediately idle, valid = 00, fill = 0, reserved_cnt = 0.

Source files
------------

// File: rtl/dual_lane_feeder.sv
// Two-lane FIFO feeder: each lane buffers DEPTH words behind a valid/ready
// handshake and pops one word per cycle into registered outputs; idle code
// (32'h1f) is driven when a lane has nothing to present and reserved-code
// words are counted.
// Ports: clk, reset_n (async low); laneN_data/valid/ready (N=0,1); flush;
// pipeline1_outputs/pipeline2_outputs, valid[1:0]; fill0/fill1; reserved_cnt.
// Option: define RESERVED_DROP_EN to drop reserved-code words instead of
// buffering them (they are still handshaken and counted).
module dual_lane_feeder #(
  parameter int DEPTH      = 4,
  parameter bit SYNC_LANES = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [31:0]              lane0_data,
  input  logic                     lane0_valid,
  output logic                     lane0_ready,
  input  logic [31:0]              lane1_data,
  input  logic                     lane1_valid,
  output logic                     lane1_ready,
  input  logic                     flush,
  output logic [31:0]              pipeline1_outputs,
  output logic [31:0]              pipeline2_outputs,
  output logic [1:0]               valid,
  output logic [$clog2(DEPTH):0]   fill0,
  output logic [$clog2(DEPTH):0]   fill1,
  output logic [15:0]              reserved_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [31:0] IDLE = 32'h0000_001F;
  localparam logic [FW-1:0] FULL = FW'(DEPTH);

  logic [31:0]   r_mem [2][DEPTH];
  logic [AW-1:0] r_wp  [2];
  logic [AW-1:0] r_rp  [2];
  logic [FW-1:0] r_fill[2];
  logic [31:0]   r_out [2];
  logic [1:0]    r_vld;
  logic [15:0]   r_rcnt;

  logic [31:0] w_data [2];
  logic [1:0]  w_in_vld;
  logic [1:0]  w_ready;
  logic [1:0]  w_acc;
  logic [1:0]  w_rsv;
  logic [1:0]  w_wr;
  logic [1:0]  w_ne;
  logic [1:0]  w_pop;
  logic [16:0] w_sum;
  logic [15:0] w_rnext;

  always_comb begin
    w_data[0]   = lane0_data;
    w_data[1]   = lane1_data;
    w_in_vld    = {lane1_valid, lane0_valid};
    w_ready     = '0;
    w_acc       = '0;
    w_rsv       = '0;
    w_wr        = '0;
    w_ne        = '0;
    for (int i = 0; i < 2; i++) begin
      w_ready[i] = (r_fill[i] != FULL) && !flush;
      w_acc[i]   = w_in_vld[i] && w_ready[i];
      w_rsv[i]   = w_acc[i] && (w_data[i][4:0] == 5'h1f);
`ifdef RESERVED_DROP_EN
      w_wr[i]    = w_acc[i] && !w_rsv[i];
`else
      w_wr[i]    = w_acc[i];
`endif
      w_ne[i]    = (r_fill[i] != '0);
    end
    // lockstep mode pops only when both lanes have a head word
    if (SYNC_LANES) w_pop = {2{&w_ne}};
    else            w_pop = w_ne;
    w_sum   = {1'b0, r_rcnt} + 17'(w_rsv[0]) + 17'(w_rsv[1]);
    w_rnext = w_sum[16] ? 16'hFFFF : w_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < DEPTH; j++) r_mem[i][j] <= '0;
        r_wp[i]   <= '0;
        r_rp[i]   <= '0;
        r_fill[i] <= '0;
        r_out[i]  <= IDLE;
      end
      r_vld  <= '0;
      r_rcnt <= '0;
    end else begin
      r_rcnt <= w_rnext;
      if (flush) begin
        for (int i = 0; i < 2; i++) begin
          r_wp[i]   <= '0;
          r_rp[i]   <= '0;
          r_fill[i] <= '0;
          r_out[i]  <= IDLE;
        end
        r_vld <= '0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (w_wr[i]) begin
            r_mem[i][r_wp[i]] <= w_data[i];
            r_wp[i] <= r_wp[i] + 1'b1;
          end
          if (w_pop[i]) begin
            r_out[i] <= r_mem[i][r_rp[i]];
            r_rp[i]  <= r_rp[i] + 1'b1;
            r_vld[i] <= 1'b1;
          end else begin
            r_out[i] <= IDLE;
            r_vld[i] <= 1'b0;
          end
          r_fill[i] <= r_fill[i] + FW'(w_wr[i]) - FW'(w_pop[i]);
        end
      end
    end
  end

  assign lane0_ready       = w_ready[0];
  assign lane1_ready       = w_ready[1];
  assign pipeline1_outputs = r_out[0];
  assign pipeline2_outputs = r_out[1];
  assign valid             = r_vld;
  assign fill0             = r_fill[0];
  assign fill1             = r_fill[1];
  assign reserved_cnt      = r_rcnt;

endmodule

// File: tb/tb_dual_lane_feeder.sv
// Bench for dual_lane_feeder: two instances (independent and lockstep)
// share stimulus; a queue model feeds a scoreboard read by a monitor.
module tb_dual_lane_feeder;

  localparam int DEPTH = 4;
`ifdef RESERVED_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif
  localparam logic [31:0] IDLE = 32'h0000_001F;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] lane0_data, lane1_data;
  logic        lane0_valid, lane1_valid, flush;

  logic [31:0] a_p1, a_p2, b_p1, b_p2;
  logic [1:0]  a_v, b_v;
  logic [2:0]  a_f0, a_f1, b_f0, b_f1;
  logic        a_r0, a_r1, b_r0, b_r1;
  logic [15:0] a_rc, b_rc;

  int ntest = 0;
  int nfail = 0;
  bit mon_en = 1'b0;

  logic [31:0] mq  [2][2][$];
  logic [31:0] sbq [2][2][$];
  int          mcnt[2];

  always #5 clk = ~clk;

  dual_lane_feeder #(.DEPTH(DEPTH), .SYNC_LANES(1'b0)) u_a (
    .clk(clk), .reset_n(reset_n),
    .lane0_data(lane0_data), .lane0_valid(lane0_valid),
    .lane0_ready(a_r0),
    .lane1_data(lane1_data), .lane1_valid(lane1_valid),
    .lane1_ready(a_r1),
    .flush(flush),
    .pipeline1_outputs(a_p1), .pipeline2_outputs(a_p2),
    .valid(a_v), .fill0(a_f0), .fill1(a_f1),
    .reserved_cnt(a_rc)
  );

  dual_lane_feeder #(.DEPTH(DEPTH), .SYNC_LANES(1'b1)) u_b (
    .clk(clk), .reset_n(reset_n),
    .lane0_data(lane0_data), .lane0_valid(lane0_valid),
    .lane0_ready(b_r0),
    .lane1_data(lane1_data), .lane1_valid(lane1_valid),
    .lane1_ready(b_r1),
    .flush(flush),
    .pipeline1_outputs(b_p1), .pipeline2_outputs(b_p2),
    .valid(b_v), .fill0(b_f0), .fill1(b_f1),
    .reserved_cnt(b_rc)
  );

  task automatic chk(input string nm, input int d,
                     input logic [31:0] act, input logic [31:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, d, act, exp);
    end
  endtask

  task automatic model_step(input int d);
    int  sz [2];
    bit  pop [2];
    bit  acc;
    bit  rsv;
    int  n;
    logic [31:0] w;
    logic [31:0] dat;
    for (int l = 0; l < 2; l++) sz[l] = mq[d][l].size();
    if (flush) begin
      for (int l = 0; l < 2; l++) mq[d][l].delete();
      return;
    end
    for (int l = 0; l < 2; l++)
      pop[l] = (d == 1) ? (sz[0] > 0 && sz[1] > 0) : (sz[l] > 0);
    n = 0;
    for (int l = 0; l < 2; l++) begin
      if (pop[l]) begin
        w = mq[d][l].pop_front();
        sbq[d][l].push_back(w);
      end
      dat = l ? lane1_data : lane0_data;
      acc = (l ? lane1_valid : lane0_valid) && (sz[l] < DEPTH);
      if (acc) begin
        rsv = (dat[4:0] == 5'h1f);
        if (rsv) n++;
        if (!(DROP && rsv)) mq[d][l].push_back(dat);
      end
    end
    mcnt[d] = (mcnt[d] + n > 65535) ? 65535 : mcnt[d] + n;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < 2; d++) begin
        for (int l = 0; l < 2; l++) begin
          mq[d][l].delete();
          sbq[d][l].delete();
        end
        mcnt[d] = 0;
      end
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic mon(input int d, input logic [31:0] o1,
                     input logic [31:0] o2, input logic [1:0] v,
                     input logic [2:0] f0, input logic [2:0] f1,
                     input logic r0, input logic r1,
                     input logic [15:0] rc);
    logic [31:0] o [2];
    logic [2:0]  f [2];
    logic        r [2];
    logic [31:0] e;
    o[0] = o1; o[1] = o2;
    f[0] = f0; f[1] = f1;
    r[0] = r0; r[1] = r1;
    for (int l = 0; l < 2; l++) begin
      if (v[l]) begin
        chk(l ? "sb_has1" : "sb_has0", d,
            32'(sbq[d][l].size() != 0), 32'd1);
        if (sbq[d][l].size() != 0) begin
          e = sbq[d][l].pop_front();
          chk(l ? "word1" : "word0", d, o[l], e);
        end
      end else begin
        chk(l ? "missing1" : "missing0", d,
            32'(sbq[d][l].size()), 32'd0);
        sbq[d][l].delete();
        chk(l ? "idle1" : "idle0", d, o[l], IDLE);
      end
      chk(l ? "fill1" : "fill0", d, 32'(f[l]),
          32'(mq[d][l].size()));
      chk(l ? "ready1" : "ready0", d, 32'(r[l]),
          32'(mq[d][l].size() < DEPTH && !flush));
    end
    chk("rcnt", d, 32'(rc), 32'(mcnt[d]));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        mon(0, a_p1, a_p2, a_v, a_f0, a_f1, a_r0, a_r1, a_rc);
        mon(1, b_p1, b_p2, b_v, b_f0, b_f1, b_r0, b_r1, b_rc);
      end
    end
  end

  task automatic pulse_flush();
    @(negedge clk);
    lane0_valid = 0; lane1_valid = 0; flush = 1;
    @(negedge clk);
    flush = 0;
  endtask

  initial begin
    int pre0, pre1;
    reset_n = 1; flush = 0;
    lane0_valid = 0; lane1_valid = 0;
    lane0_data = 0; lane1_data = 0;
    #1 reset_n = 0;
    #1 mon_en = 1;
    repeat (2) @(negedge clk);
    #2 reset_n = 1;

    @(posedge clk); #1;
    chk("rst_valid", 0, 32'(a_v), 0);
    chk("rst_out1", 0, a_p1, IDLE);
    chk("rst_out2", 1, b_p2, IDLE);
    chk("rst_ready0", 0, 32'(a_r0), 1);
    chk("rst_ready1", 1, 32'(b_r1), 1);
    chk("rst_fill", 1, 32'(b_f0), 0);

    @(negedge clk);
    lane0_valid = 1; lane0_data = 32'hDEAD_BEE0;
    @(negedge clk);
    lane0_valid = 0;
    @(posedge clk); #1;
    chk("single_word", 0, a_p1, 32'hDEAD_BEE0);
    chk("single_valid", 0, 32'(a_v), 32'h1);
    @(posedge clk); #1;
    chk("single_after_v", 0, 32'(a_v), 0);
    chk("single_after_o", 0, a_p1, IDLE);

    pulse_flush();
    @(negedge clk);
    lane1_valid = 1;
    for (int k = 1; k <= 4; k++) begin
      lane1_data = 32'(k) * 32'h100;
      @(negedge clk);
    end
    lane1_data = 32'h500;
    chk("full_fill1", 1, 32'(b_f1), 4);
    chk("full_ready1", 1, 32'(b_r1), 0);
    lane1_valid = 0;
    lane0_valid = 1; lane0_data = 32'hA0;
    @(negedge clk);
    lane0_data = 32'hA1;
    @(posedge clk); #1;
    chk("lock_fill1", 1, 32'(b_f1), 3);
    chk("lock_out2", 1, b_p2, 32'h100);
    chk("lock_out1", 1, b_p1, 32'hA0);
    chk("lock_valid", 1, 32'(b_v), 32'h3);
    @(negedge clk); lane0_data = 32'hA2;
    @(negedge clk); lane0_data = 32'hA3;
    @(negedge clk); lane0_valid = 0;
    repeat (2) @(negedge clk);

    pulse_flush();
    lane0_valid = 1; lane0_data = 32'hB0;
    @(negedge clk); lane0_data = 32'hB1;
    @(negedge clk); lane0_data = 32'hB2;
    @(negedge clk); lane0_data = 32'hB3;
    flush = 1;
    #1;
    chk("flush_fill_pre", 1, 32'(b_f0), 3);
    chk("flush_ready", 1, 32'(b_r0), 0);
    @(negedge clk);
    flush = 0; lane0_valid = 0;
    chk("flush_fill", 1, 32'(b_f0), 0);
    chk("flush_valid", 1, 32'(b_v), 0);
    chk("flush_fill_a", 0, 32'(a_f0), 0);

    pulse_flush();
    pre0 = mcnt[0]; pre1 = mcnt[1];
    lane0_valid = 1; lane1_valid = 1;
    lane0_data = 32'hFF; lane1_data = 32'hFF;
    @(negedge clk);
    lane0_valid = 0; lane1_valid = 0;
    chk("rsv_cnt", 0, 32'(a_rc), 32'(pre0 + 2));
    chk("rsv_cnt", 1, 32'(b_rc), 32'(pre1 + 2));
    @(posedge clk); #1;
    if (DROP) begin
      chk("rsv_drop_v", 0, 32'(a_v), 0);
      chk("rsv_drop_f", 1, 32'(b_f0), 0);
    end else begin
      chk("rsv_fwd_v", 0, 32'(a_v), 32'h3);
      chk("rsv_fwd_o", 1, b_p2, 32'hFF);
    end

    pulse_flush();
    lane0_valid = 1; lane0_data = 32'hC0;
    @(negedge clk);
    lane0_data = 32'hC1; lane1_valid = 1; lane1_data = 32'hD0;
    @(negedge clk);
    lane0_data = 32'hC2; lane1_data = 32'hD1;
    @(negedge clk);
    lane0_valid = 0; lane1_valid = 0;
    chk("pre_rst_f0", 1, 32'(b_f0), 2);
    chk("pre_rst_f1", 1, 32'(b_f1), 1);
    chk("pre_rst_v", 1, 32'(b_v), 32'h3);
    #2 reset_n = 0;
    #1;
    chk("arst_valid", 1, 32'(b_v), 0);
    chk("arst_out1", 1, b_p1, IDLE);
    chk("arst_out2", 1, b_p2, IDLE);
    chk("arst_fill0", 1, 32'(b_f0), 0);
    chk("arst_fill1", 1, 32'(b_f1), 0);
    chk("arst_rcnt", 1, 32'(b_rc), 0);
    chk("arst_rcnt", 0, 32'(a_rc), 0);
    @(negedge clk);
    reset_n = 1;

    repeat (3000) begin
      @(negedge clk);
      lane0_valid = ($urandom_range(0, 3) != 0);
      lane1_valid = ($urandom_range(0, 3) != 0);
      lane0_data  = $urandom;
      lane1_data  = $urandom;
      if ($urandom_range(0, 7) == 0) lane0_data[4:0] = 5'h1f;
      if ($urandom_range(0, 7) == 0) lane1_data[4:0] = 5'h1f;
      flush = ($urandom_range(0, 63) == 0);
    end

    @(negedge clk);
    flush = 0; lane0_valid = 0; lane1_valid = 0;
    #2 reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    lane0_valid = 1; lane1_valid = 1;
    repeat (32770) begin
      lane0_data = {$urandom_range(0, 32'h07FF_FFFF), 5'h1f};
      lane1_data = {$urandom_range(0, 32'h07FF_FFFF), 5'h1f};
      @(negedge clk);
    end
    lane0_valid = 0; lane1_valid = 0;
    @(posedge clk); #1;
    chk("sat_cnt", 0, 32'(a_rc), 32'hFFFF);
    chk("sat_cnt", 1, 32'(b_rc), 32'hFFFF);

    repeat (3) @(posedge clk);
    #2;
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < 2; l++)
        chk("sb_drained", d, 32'(sbq[d][l].size()), 0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
